// File: rtl/altera_tse_pma_word_aligner.sv
// TBI comma word aligner: searches a two-word window for a 7-bit comma,
// locks onto its bit offset and emits re-aligned code-groups one clock later.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// UNLOCKED  | hunting for a comma at any offset, offset_out retained
// ACQUIRE   | candidate offset chosen, counting commas seen there
// LOCKED    | offset frozen, sync_status high, watching for loss of alignment
module altera_tse_pma_word_aligner #(
    parameter  int DATA_WIDTH     = 10,
    parameter  int REVERSE_BITS   = 1,
    parameter  int LOCK_COUNT     = 3,
    parameter  int MISALIGN_COUNT = 4,
    parameter  int UNLOCK_TIMEOUT = 255,
    localparam int OFF_W          = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  realign,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  comma_det,
    output logic                  sync_status,
    output logic [OFF_W-1:0]      offset_out
);

    localparam int NSYM  = DATA_WIDTH / 10;
    localparam int WIN_W = 2 * DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [OFF_W-1:0]      offset, offset_n;
    logic [3:0]            acq_cnt, acq_n, acq_inc;
    logic [3:0]            mis_cnt, mis_n, mis_inc;
    logic [15:0]           timer, timer_n, timer_inc;
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] cur_r;
    logic [DATA_WIDTH-1:0] slice_n;
    logic [WIN_W-1:0]      win;
    logic                  primed;
    logic                  comma_any;
    logic                  comma_cur;
    logic                  comma_out;
    logic [OFF_W-1:0]      comma_k;

    function automatic logic is_comma(input logic [6:0] s);
        return (s == 7'b1111100) || (s == 7'b0000011);
    endfunction

    // LVDS deserialisers deliver each symbol MSB-first; flip so bit 0 is bit a.
    always_comb begin
        r = din;
        if (REVERSE_BITS != 0) begin
            for (int s = 0; s < NSYM; s++) begin
                for (int b = 0; b < 10; b++) begin
                    r[s*10+b] = din[s*10+9-b];
                end
            end
        end
    end

    // Top bit of r can never fall inside a slice, so it is left out of the window.
    assign win = {r[DATA_WIDTH-2:0], cur_r};

    // Descending scan so the lowest matching offset is the one that sticks.
    always_comb begin
        comma_any = 1'b0;
        comma_cur = 1'b0;
        comma_k   = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            if (is_comma(win[k +: 7])) begin
                comma_any = 1'b1;
                comma_k   = OFF_W'(k);
                if (OFF_W'(k) == offset) begin
                    comma_cur = 1'b1;
                end
            end
        end
    end

    assign acq_inc   = (acq_cnt == 4'hF)     ? acq_cnt : acq_cnt + 4'd1;
    assign mis_inc   = (mis_cnt == 4'hF)     ? mis_cnt : mis_cnt + 4'd1;
    assign timer_inc = (timer   == 16'hFFFF) ? timer   : timer + 16'd1;

    always_comb begin
        state_n  = state;
        offset_n = offset;
        acq_n    = acq_cnt;
        mis_n    = mis_cnt;
        timer_n  = timer;
        if (realign) begin
            state_n = ST_UNLOCKED;
            acq_n   = '0;
            mis_n   = '0;
            timer_n = '0;
        end else if (din_valid) begin
            case (state)
                ST_UNLOCKED: begin
                    if (comma_any) begin
                        offset_n = comma_k;
                        acq_n    = 4'd1;
                        timer_n  = '0;
                        state_n  = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (comma_cur) begin
                        acq_n   = acq_inc;
                        timer_n = '0;
                        if (acq_inc == 4'(LOCK_COUNT)) begin
                            state_n = ST_LOCKED;
                        end
                    end else if (comma_any) begin
                        offset_n = comma_k;
                        acq_n    = 4'd1;
                        timer_n  = '0;
                    end else if (timer_inc == 16'(UNLOCK_TIMEOUT)) begin
                        state_n = ST_UNLOCKED;
                        acq_n   = '0;
                        mis_n   = '0;
                        timer_n = '0;
                    end else begin
                        timer_n = timer_inc;
                    end
                end
                ST_LOCKED: begin
                    if (comma_cur) begin
                        timer_n = '0;
                        mis_n   = '0;
                    end else if (comma_any && (mis_inc == 4'(MISALIGN_COUNT))) begin
                        state_n = ST_UNLOCKED;
                        acq_n   = '0;
                        mis_n   = '0;
                        timer_n = '0;
                    end else if (comma_any) begin
                        mis_n   = mis_inc;
                        timer_n = timer_inc;
                    end else if (timer_inc == 16'(UNLOCK_TIMEOUT)) begin
                        state_n = ST_UNLOCKED;
                        acq_n   = '0;
                        mis_n   = '0;
                        timer_n = '0;
                    end else begin
                        timer_n = timer_inc;
                    end
                end
                default: begin
                    state_n = ST_UNLOCKED;
                    acq_n   = '0;
                    mis_n   = '0;
                    timer_n = '0;
                end
            endcase
        end
    end

    // The word carrying a freshly found comma is already emitted at its new offset.
    always_comb begin
        slice_n = win[DATA_WIDTH-1:0];
        for (int k = 0; k < DATA_WIDTH; k++) begin
            if (OFF_W'(k) == offset_n) begin
                slice_n = win[k +: DATA_WIDTH];
            end
        end
    end

    assign comma_out = is_comma(slice_n[6:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_UNLOCKED;
            offset      <= '0;
            acq_cnt     <= '0;
            mis_cnt     <= '0;
            timer       <= '0;
            cur_r       <= '0;
            primed      <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            comma_det   <= 1'b0;
            sync_status <= 1'b0;
            offset_out  <= '0;
        end else begin
            state       <= state_n;
            offset      <= offset_n;
            acq_cnt     <= acq_n;
            mis_cnt     <= mis_n;
            timer       <= timer_n;
            sync_status <= (state_n == ST_LOCKED);
            offset_out  <= offset_n;
            if (din_valid) begin
                cur_r      <= r;
                primed     <= 1'b1;
                dout       <= slice_n;
                comma_det  <= comma_out;
                dout_valid <= primed;
            end else begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_altera_tse_pma_word_aligner.sv
// Scoreboard bench: directed words push hand-computed expectations, and a
// monitor per DUT pops and compares whenever dout_valid is seen.
module tb_altera_tse_pma_word_aligner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 10-bit, no reversal, short timeout
    logic        reset_a, din_valid_a, realign_a;
    logic [9:0]  din_a, dout_a;
    logic        dout_valid_a, comma_det_a, sync_status_a;
    logic [3:0]  offset_out_a;

    // DUT B: 20-bit, reversed symbols
    logic        reset_b, din_valid_b, realign_b;
    logic [19:0] din_b, dout_b;
    logic        dout_valid_b, comma_det_b, sync_status_b;
    logic [4:0]  offset_out_b;

    altera_tse_pma_word_aligner #(
        .DATA_WIDTH(10), .REVERSE_BITS(0), .LOCK_COUNT(3),
        .MISALIGN_COUNT(4), .UNLOCK_TIMEOUT(8)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .din(din_a), .din_valid(din_valid_a),
        .realign(realign_a), .dout(dout_a), .dout_valid(dout_valid_a),
        .comma_det(comma_det_a), .sync_status(sync_status_a),
        .offset_out(offset_out_a)
    );

    altera_tse_pma_word_aligner #(
        .DATA_WIDTH(20), .REVERSE_BITS(1), .LOCK_COUNT(3),
        .MISALIGN_COUNT(4), .UNLOCK_TIMEOUT(255)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .din(din_b), .din_valid(din_valid_b),
        .realign(realign_b), .dout(dout_b), .dout_valid(dout_valid_b),
        .comma_det(comma_det_b), .sync_status(sync_status_b),
        .offset_out(offset_out_b)
    );

    typedef struct packed {
        logic [19:0] dout;
        logic        comma;
        logic        sync;
        logic [4:0]  off;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [9:0]  X = 10'h3E2;  // 0x17C rotated: comma at k=3
    localparam logic [9:0]  Y = 10'h1D0;  // 0x283 rotated: comma at k=7
    localparam logic [19:0] D = 20'h3E8FA; // two 0x0FA symbols (MSB-first 0x17C)

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step_a(input logic [9:0] d, input logic v, input logic push,
                          input logic [9:0] ed, input logic ec, input logic es,
                          input logic [3:0] eo);
        exp_t e;
        din_a       = d;
        din_valid_a = v;
        if (push) begin
            e.dout  = 20'(ed);
            e.comma = ec;
            e.sync  = es;
            e.off   = 5'(eo);
            q_a.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [9:0] d, input logic [9:0] ed, input logic ec,
                          input logic es, input logic [3:0] eo);
        step_a(d, 1'b1, 1'b1, ed, ec, es, eo);
    endtask

    task automatic idle_a();
        step_a(10'h0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic realign_pulse_a();
        realign_a   = 1'b1;
        din_valid_a = 1'b0;
        @(posedge clk);
        #1;
        realign_a = 1'b0;
    endtask

    task automatic send_b(input logic [19:0] d, input logic push, input logic [19:0] ed,
                          input logic ec, input logic es, input logic [4:0] eo);
        exp_t e;
        din_b       = d;
        din_valid_b = 1'b1;
        if (push) begin
            e.dout  = ed;
            e.comma = ec;
            e.sync  = es;
            e.off   = eo;
            q_b.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_valid_a === 1'b1) begin
                if (q_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL a_unexpected_valid actual=1 required=0");
                end else begin
                    e = q_a.pop_front();
                    check("a_dout",   32'(dout_a),        32'(e.dout[9:0]));
                    check("a_comma",  32'(comma_det_a),   32'(e.comma));
                    check("a_sync",   32'(sync_status_a), 32'(e.sync));
                    check("a_offset", 32'(offset_out_a),  32'(e.off[3:0]));
                end
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (dout_valid_b === 1'b1) begin
                if (q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_valid actual=1 required=0");
                end else begin
                    e = q_b.pop_front();
                    check("b_dout",   32'(dout_b),        32'(e.dout));
                    check("b_comma",  32'(comma_det_b),   32'(e.comma));
                    check("b_sync",   32'(sync_status_b), 32'(e.sync));
                    check("b_offset", 32'(offset_out_b),  32'(e.off));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset_a = 1'b1; din_valid_a = 1'b1; din_a = X; realign_a = 1'b0;
        reset_b = 1'b1; din_valid_b = 1'b0; din_b = '0; realign_b = 1'b0;

        // reset held three clocks with din_valid high
        repeat (3) @(posedge clk);
        #1;
        check("a_rst_dout",   32'(dout_a),        32'h0);
        check("a_rst_valid",  32'(dout_valid_a),  32'h0);
        check("a_rst_comma",  32'(comma_det_a),   32'h0);
        check("a_rst_sync",   32'(sync_status_a), 32'h0);
        check("a_rst_offset", 32'(offset_out_a),  32'h0);
        reset_a = 1'b0;

        // first word after reset only primes the window
        step_a(X, 1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 4'h0);
        check("a_first_valid", 32'(dout_valid_a), 32'h0);

        // acquire at k=3, lock after third comma word
        send_a(X, 10'h17C, 1'b1, 1'b0, 4'd3);
        send_a(X, 10'h17C, 1'b1, 1'b0, 4'd3);
        send_a(X, 10'h17C, 1'b1, 1'b1, 4'd3);
        send_a(X, 10'h17C, 1'b1, 1'b1, 4'd3);

        // timeout: last comma drains out, then 8 comma-free words with gaps
        send_a(10'h000, 10'h07C, 1'b1, 1'b1, 4'd3);
        for (int i = 0; i < 8; i++) begin
            send_a(10'h000, 10'h000, 1'b0, (i < 7), 4'd3);
            if (i % 2 == 0) idle_a();
        end

        // relock at k=3
        send_a(X, 10'h100, 1'b0, 1'b0, 4'd3);
        send_a(X, 10'h17C, 1'b1, 1'b0, 4'd3);
        send_a(X, 10'h17C, 1'b1, 1'b0, 4'd3);
        send_a(X, 10'h17C, 1'b1, 1'b1, 4'd3);

        // commas move to k=7: four misaligned words break lock
        send_a(Y, 10'h07C, 1'b1, 1'b1, 4'd3);
        send_a(Y, 10'h03A, 1'b0, 1'b1, 4'd3);
        send_a(Y, 10'h03A, 1'b0, 1'b1, 4'd3);
        send_a(Y, 10'h03A, 1'b0, 1'b1, 4'd3);
        send_a(Y, 10'h03A, 1'b0, 1'b0, 4'd3);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b1, 4'd7);

        // realign from LOCKED, then again mid-ACQUIRE
        realign_pulse_a();
        check("a_realign_sync",   32'(sync_status_a), 32'h0);
        check("a_realign_offset", 32'(offset_out_a),  32'h7);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        realign_pulse_a();
        check("a_realign_acq_sync", 32'(sync_status_a), 32'h0);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b1, 4'd7);

        // reset mid-ACQUIRE
        realign_pulse_a();
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        reset_a     = 1'b1;
        din_valid_a = 1'b1;
        din_a       = Y;
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        check("a_rst2_sync",   32'(sync_status_a), 32'h0);
        check("a_rst2_offset", 32'(offset_out_a),  32'h0);
        check("a_rst2_valid",  32'(dout_valid_a),  32'h0);
        check("a_rst2_dout",   32'(dout_a),        32'h0);
        step_a(Y, 1'b1, 1'b0, 10'h0, 1'b0, 1'b0, 4'h0);
        check("a_rst2_first_valid", 32'(dout_valid_a), 32'h0);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b0, 4'd7);
        send_a(Y, 10'h283, 1'b1, 1'b1, 4'd7);
        idle_a();

        // 20-bit DUT with per-symbol bit reversal
        repeat (2) @(posedge clk);
        #1;
        reset_b = 1'b0;
        send_b(D, 1'b0, 20'h0, 1'b0, 1'b0, 5'd0);
        check("b_first_valid", 32'(dout_valid_b), 32'h0);
        send_b(D, 1'b1, 20'h5F17C, 1'b1, 1'b0, 5'd0);
        send_b(D, 1'b1, 20'h5F17C, 1'b1, 1'b0, 5'd0);
        send_b(D, 1'b1, 20'h5F17C, 1'b1, 1'b1, 5'd0);
        din_valid_b = 1'b0;

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(posedge clk);
        end
        #1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d required=0", q_a.size() + q_b.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/altera_tse_pma_word_aligner.md
ALTERA_TSE_PMA_WORD_ALIGNER -- requirements
Module: altera_tse_pma_word_aligner

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, TBI word width; legal 10 or 20 (1 or 2 code-groups).
REQ-002 SHALL have parameter REVERSE_BITS, default 1; 1 = reverse bit order within each 10-bit symbol on input (LVDS MSB-first delivery).
REQ-003 SHALL have parameter LOCK_COUNT, default 3, range 1..15; aligned commas needed to lock.
REQ-004 SHALL have parameter MISALIGN_COUNT, default 4, range 1..15; consecutive off-offset commas that break lock.
REQ-005 SHALL have parameter UNLOCK_TIMEOUT, default 255, range 1..65535; valid words without aligned comma before lock drops.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 din  in  DATA_WIDTH  raw TBI word from PMA; bit 0 = bit a after optional reversal.
REQ-009 din_valid  in  1  qualifies din; all state advances only when high.
REQ-010 realign  in  1  one-cycle request forcing state UNLOCKED.
REQ-011 dout  out  DATA_WIDTH  aligned TBI word.
REQ-012 dout_valid  out  1  qualifies dout.
REQ-013 comma_det  out  1  dout[6:0] holds a comma, aligned with dout.
REQ-014 sync_status  out  1  high in LOCKED.
REQ-015 offset_out  out  clog2(DATA_WIDTH)  current alignment offset.

Function
REQ-016 SHALL form r = din with each 10-bit symbol bit-reversed when REVERSE_BITS=1, else r = din.
REQ-017 SHALL hold cur_r (previous valid r); window W = {r, cur_r}, 2*DATA_WIDTH bits; on din_valid, cur_r <= r.
REQ-018 Slice(k) = W[k+DATA_WIDTH-1:k], k in 0..DATA_WIDTH-1.
REQ-019 Comma at k: Slice(k)[6:0] equals 7'b1111100 or 7'b0000011; only symbol-0 position is searched.
REQ-020 Multiple comma offsets in one word: lowest k SHALL win.
REQ-021 On din_valid: dout <= Slice(offset_next), comma_det <= comma at offset_next; dout_valid <= 1 only if a prior valid word has been captured since reset (primed), else 0; with din_valid low, dout_valid <= 0 and dout holds; latency 1 clock.
REQ-022 States: UNLOCKED, ACQUIRE, LOCKED; counters acq_cnt, mis_cnt, timer.
REQ-023 UNLOCKED: comma at k -> offset<=k, acq_cnt<=1, timer<=0, next ACQUIRE (LOCKED directly if LOCK_COUNT=1); else stay, offset held.
REQ-024 ACQUIRE: comma at current offset -> acq_cnt+1, timer<=0, LOCKED when acq_cnt+1 = LOCK_COUNT; comma only at other k -> offset<=k, acq_cnt<=1, timer<=0; no comma -> timer+1, UNLOCKED when timer+1 = UNLOCK_TIMEOUT.
REQ-025 LOCKED: offset frozen; comma at current offset -> timer<=0, mis_cnt<=0; comma only at other k -> mis_cnt+1, timer+1, UNLOCKED when mis_cnt+1 = MISALIGN_COUNT; no comma -> timer+1, mis_cnt unchanged, UNLOCKED when timer+1 = UNLOCK_TIMEOUT.
REQ-026 Entry to UNLOCKED SHALL clear acq_cnt, mis_cnt, timer; offset retained.
REQ-027 offset_next = offset updated this cycle (new k in UNLOCKED/ACQUIRE), so comma word is emitted aligned.
REQ-028 realign high SHALL force UNLOCKED next clock regardless of din_valid; priority over all transitions except reset.
REQ-029 Counters SHALL saturate, never wrap.
REQ-030 sync_status SHALL be registered, high exactly when state = LOCKED.

Reset
REQ-031 reset high at a clock edge: state UNLOCKED; offset, counters, cur_r, primed, dout, dout_valid, comma_det, sync_status, offset_out all 0.
REQ-032 reset SHALL override din_valid and realign, and abort any ACQUIRE/LOCKED state.

Verification
REQ-033 Reset 3 clocks with din_valid=1 -> all outputs 0; first valid word after release -> dout_valid stays 0.
REQ-034 DATA_WIDTH=10, REVERSE_BITS=0, LOCK_COUNT=3: repeated 0x17C shifted so comma at k=3 -> offset_out=3 after 1st comma, dout=0x17C, comma_det=1, sync_status=1 the clock after the 3rd comma word.
REQ-035 LOCKED, UNLOCK_TIMEOUT=8, eight non-comma valid words (din_valid gaps interleaved) -> sync_status 0 after 8th valid word, not earlier.
REQ-036 LOCKED at k=3, 0x283 commas moved to k=7, MISALIGN_COUNT=4 -> unlock after 4th; next comma -> offset_out=7; relock after 3 more.
REQ-037 DATA_WIDTH=20, REVERSE_BITS=1: din symbol0 = 0x0FA repeated -> dout[9:0]=0x17C, offset_out=0, comma_det=1.
REQ-038 reset or realign asserted mid-ACQUIRE (acq_cnt=2) -> state UNLOCKED, sync_status 0, acq_cnt 0 next clock.
